// File: rtl/exe_stage.sv
// Execute stage: registers the decode payload, runs the ALU and issues data-SRAM requests.
// Optional misaligned-access suppression is enabled by defining EXE_MISALIGN_CHK_EN.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [147:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [71:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [4:0]   es_to_ds_dest,
    output logic [31:0]  es_to_ds_value,
    output logic         es_value_from_mem
);

    logic         r_es_valid;
    logic [147:0] r_es_bus;

    logic [31:0] w_pc;
    logic [11:0] w_alu_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_rkd_value;
    logic        w_res_from_mem;
    logic        w_mem_we;
    logic [4:0]  w_dest;
    logic        w_gr_we;

    assign w_pc           = r_es_bus[147:116];
    assign w_alu_op       = r_es_bus[115:104];
    assign w_a            = r_es_bus[103:72];
    assign w_b            = r_es_bus[71:40];
    assign w_rkd_value    = r_es_bus[39:8];
    assign w_res_from_mem = r_es_bus[7];
    assign w_mem_we       = r_es_bus[6];
    assign w_dest         = r_es_bus[5:1];
    assign w_gr_we        = r_es_bus[0];

    logic w_es_ready_go;
    assign w_es_ready_go = 1'b1;
    assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
    assign es_to_ms_valid = r_es_valid && w_es_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_valid <= 1'b0;
            r_es_bus   <= 148'd0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
            if (ds_to_es_valid) begin
                r_es_bus <= ds_to_es_bus;
            end
        end
    end

    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_slt;
    logic [31:0] w_sltu;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_alu_result;

    assign w_add  = w_a + w_b;
    assign w_sub  = w_a - w_b;
    assign w_slt  = {31'd0, $signed(w_a) < $signed(w_b)};
    assign w_sltu = {31'd0, w_a < w_b};
    assign w_sll  = w_a << w_b[4:0];
    assign w_srl  = w_a >> w_b[4:0];
    assign w_sra  = $unsigned($signed(w_a) >>> w_b[4:0]);

    // alu_op is one-hot from decode; OR-ing the masked results keeps the mux flat.
    assign w_alu_result = ({32{w_alu_op[0]}}  & w_add)
                        | ({32{w_alu_op[1]}}  & w_sub)
                        | ({32{w_alu_op[2]}}  & w_slt)
                        | ({32{w_alu_op[3]}}  & w_sltu)
                        | ({32{w_alu_op[4]}}  & (w_a & w_b))
                        | ({32{w_alu_op[5]}}  & ~(w_a | w_b))
                        | ({32{w_alu_op[6]}}  & (w_a | w_b))
                        | ({32{w_alu_op[7]}}  & (w_a ^ w_b))
                        | ({32{w_alu_op[8]}}  & w_sll)
                        | ({32{w_alu_op[9]}}  & w_srl)
                        | ({32{w_alu_op[10]}} & w_sra)
                        | ({32{w_alu_op[11]}} & w_b);

    logic w_misalign;
`ifdef EXE_MISALIGN_CHK_EN
    assign w_misalign = r_es_valid && (w_res_from_mem || w_mem_we)
                        && (w_alu_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign data_sram_en    = r_es_valid && (w_res_from_mem || w_mem_we) && !w_misalign;
    assign data_sram_we    = {4{r_es_valid && w_mem_we && !w_misalign}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rkd_value;

    assign es_to_ms_bus = {w_misalign, w_pc, w_alu_result, w_res_from_mem, w_gr_we, w_dest};

    assign es_to_ds_dest     = (r_es_valid && w_gr_we) ? w_dest : 5'd0;
    assign es_to_ds_value    = w_alu_result;
    assign es_value_from_mem = r_es_valid && w_res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized traffic against a
// behavioural model of the stage contents; follows EXE_MISALIGN_CHK_EN like the design.
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [147:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [71:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [4:0]   es_to_ds_dest;
    logic [31:0]  es_to_ds_value;
    logic         es_value_from_mem;

    exe_stage u_dut (
        .clk              (clk),
        .reset            (reset),
        .ms_allowin       (ms_allowin),
        .es_allowin       (es_allowin),
        .ds_to_es_valid   (ds_to_es_valid),
        .ds_to_es_bus     (ds_to_es_bus),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .es_to_ds_dest    (es_to_ds_dest),
        .es_to_ds_value   (es_to_ds_value),
        .es_value_from_mem(es_value_from_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: what instruction the stage holds, as a raw payload plus valid flag.
    logic         m_valid = 1'b0;
    logic [147:0] m_bus   = '0;

    logic [180:0] w_obs;
    assign w_obs = {es_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_en, data_sram_we,
                    data_sram_addr, data_sram_wdata, es_to_ds_dest, es_to_ds_value,
                    es_value_from_mem};

`ifdef EXE_MISALIGN_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    function automatic logic [147:0] make_bus(input logic [31:0] pc, input logic [11:0] op,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] rkd, input logic rfm,
                                              input logic mwe, input logic [4:0] dest,
                                              input logic grwe);
        return {pc, op, a, b, rkd, rfm, mwe, dest, grwe};
    endfunction

    function automatic logic [31:0] alu_one(input int i, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        int sh;
        logic [31:0] r;
        sa = a;
        sb = b;
        sh = int'(b % 32);
        case (i)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = (sa < sb) ? 32'd1 : 32'd0;
            3:  r = (a < b) ? 32'd1 : 32'd0;
            4:  r = a & b;
            5:  r = ~(a | b);
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = a << sh;
            9:  r = a >> sh;
            10: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            default: r = b;
        endcase
        return r;
    endfunction

    function automatic logic [180:0] model_out(input logic v, input logic [147:0] bus,
                                               input logic msa);
        logic [31:0] pc;
        logic [11:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rkd;
        logic        rfm;
        logic        mwe;
        logic [4:0]  dest;
        logic        grwe;
        logic [31:0] res;
        logic        mis;
        logic        en;
        logic [3:0]  we;
        {pc, op, a, b, rkd, rfm, mwe, dest, grwe} = bus;
        res = 32'd0;
        for (int i = 0; i < 12; i++) begin
            if (op[i]) res = res | alu_one(i, a, b);
        end
        mis = ChkEn && v && (rfm || mwe) && (res % 4 != 0);
        en  = v && (rfm || mwe) && !mis;
        we  = (v && mwe && !mis) ? 4'hF : 4'h0;
        return {(!v || msa), v, mis, pc, res, rfm, grwe, dest, en, we, res, rkd,
                ((v && grwe) ? dest : 5'd0), res, (v && rfm)};
    endfunction

    task automatic tick(input logic dv, input logic [147:0] bus, input logic msa);
        ds_to_es_valid = dv;
        ds_to_es_bus   = bus;
        ms_allowin     = msa;
        @(posedge clk);
        if (!m_valid || msa) begin
            m_valid = dv;
            if (dv) m_bus = bus;
        end
        #1;
    endtask

    task automatic test_reset;
        logic [180:0] exp;
        reset = 1'b1;
        ms_allowin = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = make_bus(32'h1C00_0000, 12'h001, 32'h5, 32'h7, 32'h9, 1'b1, 1'b1,
                                5'd3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        exp = model_out(1'b0, 148'd0, 1'b0);
        n_cmp++;
        if (w_obs !== exp) begin
            $display("FAIL reset_state got %h want %h", w_obs, exp);
            n_fail++;
        end
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0;
        m_bus = '0;
    endtask

    task automatic test_alu_directed;
        tick(1'b1, make_bus(32'h100, 12'h001, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0,
                            5'd7, 1'b1), 1'b1);
        n_cmp++;
        if (es_to_ms_bus[38:7] !== 32'h8000_0000 || es_to_ds_value !== 32'h8000_0000
            || es_to_ds_dest !== 5'd7) begin
            $display("FAIL add_w got res=%h fwd=%h dest=%0d want 80000000/80000000/7",
                     es_to_ms_bus[38:7], es_to_ds_value, es_to_ds_dest);
            n_fail++;
        end
        tick(1'b1, make_bus(32'h104, 12'h004, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0,
                            5'd8, 1'b1), 1'b1);
        n_cmp++;
        if (es_to_ms_bus[38:7] !== 32'd1) begin
            $display("FAIL slt got %h want 00000001", es_to_ms_bus[38:7]);
            n_fail++;
        end
        tick(1'b1, make_bus(32'h108, 12'h008, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0,
                            5'd8, 1'b1), 1'b1);
        n_cmp++;
        if (es_to_ms_bus[38:7] !== 32'd0) begin
            $display("FAIL sltu got %h want 00000000", es_to_ms_bus[38:7]);
            n_fail++;
        end
        tick(1'b1, make_bus(32'h10C, 12'h400, 32'h8000_0000, 32'd31, 32'h0, 1'b0, 1'b0,
                            5'd9, 1'b1), 1'b1);
        n_cmp++;
        if (es_to_ms_bus[38:7] !== 32'hFFFF_FFFF) begin
            $display("FAIL sra got %h want ffffffff", es_to_ms_bus[38:7]);
            n_fail++;
        end
        tick(1'b1, make_bus(32'h110, 12'h000, 32'h1234_5678, 32'h9, 32'h0, 1'b0, 1'b0,
                            5'd9, 1'b0), 1'b1);
        n_cmp++;
        if (es_to_ms_bus[38:7] !== 32'd0 || es_to_ds_dest !== 5'd0) begin
            $display("FAIL zero_op got res=%h dest=%0d want 0/0", es_to_ms_bus[38:7],
                     es_to_ds_dest);
            n_fail++;
        end
    endtask

    task automatic test_store;
        tick(1'b1, make_bus(32'h200, 12'h001, 32'h1000, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b1,
                            5'd0, 1'b0), 1'b1);
        n_cmp++;
        if (data_sram_en !== 1'b1 || data_sram_we !== 4'hF || data_sram_addr !== 32'h1008
            || data_sram_wdata !== 32'hDEAD_BEEF || es_value_from_mem !== 1'b0) begin
            $display("FAIL st_w got en=%b we=%h addr=%h wd=%h vfm=%b want 1/f/1008/deadbeef/0",
                     data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
                     es_value_from_mem);
            n_fail++;
        end
    endtask

    task automatic test_backpressure;
        logic [147:0] bus_a;
        logic [147:0] bus_b;
        logic [180:0] exp;
        bus_a = make_bus(32'h300, 12'h040, 32'hF0, 32'h0F, 32'h55, 1'b1, 1'b0, 5'd4, 1'b1);
        bus_b = make_bus(32'h304, 12'h080, 32'hFF, 32'h0F, 32'h66, 1'b0, 1'b0, 5'd5, 1'b1);
        tick(1'b1, bus_a, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, bus_b, 1'b0);
            exp = model_out(m_valid, m_bus, ms_allowin);
            n_cmp++;
            if (es_allowin !== 1'b0 || es_to_ms_bus[70:39] !== 32'h300 || w_obs !== exp) begin
                $display("FAIL stall_%0d got allowin=%b pc=%h obs=%h want 0/300/%h", c,
                         es_allowin, es_to_ms_bus[70:39], w_obs, exp);
                n_fail++;
            end
        end
        ms_allowin = 1'b1;
        #1;
        n_cmp++;
        if (es_allowin !== 1'b1) begin
            $display("FAIL release_allowin got %b want 1", es_allowin);
            n_fail++;
        end
        tick(1'b1, bus_b, 1'b1);
        n_cmp++;
        if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[70:39] !== 32'h304
            || es_to_ms_bus[38:7] !== 32'hF0) begin
            $display("FAIL release_accept got v=%b pc=%h res=%h want 1/304/000000f0",
                     es_to_ms_valid, es_to_ms_bus[70:39], es_to_ms_bus[38:7]);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc;
        for (int k = 0; k < 4; k++) begin
            pc = 32'h400 + 32'(k * 4);
            tick(1'b1, make_bus(pc, 12'h800, 32'h0, 32'(k * 3), 32'h0, 1'b0, 1'b0, 5'(k + 1),
                                1'b1), 1'b1);
            n_cmp++;
            if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[70:39] !== pc
                || es_to_ds_value !== 32'(k * 3)) begin
                $display("FAIL b2b_%0d got v=%b pc=%h val=%h want 1/%h/%h", k, es_to_ms_valid,
                         es_to_ms_bus[70:39], es_to_ds_value, pc, 32'(k * 3));
                n_fail++;
            end
        end
    endtask

    task automatic test_random;
        logic [147:0] bus;
        logic [180:0] exp;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [11:0]  op;
        int           sel;
        for (int c = 0; c < 400; c++) begin
            sel = int'($urandom_range(0, 12));
            op  = (sel == 12) ? 12'h000 : 12'(1 << sel);
            a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus = make_bus($urandom, op, a, b, $urandom, 1'($urandom), 1'($urandom),
                           5'($urandom), 1'($urandom));
            tick(1'($urandom_range(0, 3) != 0), bus, 1'($urandom_range(0, 2) != 0));
            exp = model_out(m_valid, m_bus, ms_allowin);
            n_cmp++;
            if (w_obs !== exp) begin
                $display("FAIL random_%0d got %h want %h", c, w_obs, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid_load;
        logic [180:0] exp;
        tick(1'b1, make_bus(32'h500, 12'h001, 32'h2000, 32'h4, 32'h0, 1'b1, 1'b0, 5'd6,
                            1'b1), 1'b0);
        ds_to_es_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (es_to_ms_valid !== 1'b0 || data_sram_en !== 1'b0 || es_value_from_mem !== 1'b0
            || es_allowin !== 1'b1 || data_sram_we !== 4'h0) begin
            $display("FAIL reset_mid_load got v=%b en=%b vfm=%b allowin=%b we=%h want 0/0/0/1/0",
                     es_to_ms_valid, data_sram_en, es_value_from_mem, es_allowin, data_sram_we);
            n_fail++;
        end
        m_valid = 1'b0;
        m_bus = '0;
        exp = model_out(1'b0, 148'd0, ms_allowin);
        n_cmp++;
        if (w_obs !== exp) begin
            $display("FAIL reset_mid_load_all got %h want %h", w_obs, exp);
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_misalign;
        tick(1'b1, make_bus(32'h600, 12'h001, 32'h1000, 32'h2, 32'h0, 1'b1, 1'b0, 5'd2,
                            1'b1), 1'b1);
        n_cmp++;
        if (data_sram_en !== !ChkEn || es_to_ms_bus[71] !== ChkEn
            || data_sram_addr !== 32'h1002) begin
            $display("FAIL misalign_ld got en=%b b71=%b addr=%h want %b/%b/1002", data_sram_en,
                     es_to_ms_bus[71], data_sram_addr, !ChkEn, ChkEn);
            n_fail++;
        end
        tick(1'b1, make_bus(32'h604, 12'h001, 32'h1000, 32'h1, 32'h1, 1'b0, 1'b1, 5'd0,
                            1'b0), 1'b1);
        n_cmp++;
        if (data_sram_we !== (ChkEn ? 4'h0 : 4'hF) || es_to_ms_bus[71] !== ChkEn) begin
            $display("FAIL misalign_st got we=%h b71=%b want %h/%b", data_sram_we,
                     es_to_ms_bus[71], (ChkEn ? 4'h0 : 4'hF), ChkEn);
            n_fail++;
        end
    endtask

    initial begin
        reset = 1'b1;
        ms_allowin = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus = '0;
        test_reset();
        test_alu_directed();
        test_store();
        test_backpressure();
        test_back_to_back();
        test_misalign();
        test_random();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
